// File: rtl/vmem_sequencer.sv
// Vector memory sequencer: splits VLDW/VLDH/VSTW/VSTB into LANES scalar accesses on one port.
// Optional abort support (flush input, DRAIN state) is compiled in with `define VMEM_FLUSH_EN.
module vmem_sequencer #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    is_store,
    input  logic                    is_half,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES*DATA_W-1:0] store_vec,
    input  logic                    flush,
    output logic                    stall,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [LANES*DATA_W-1:0] load_vec,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    mem_size,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int unsigned LaneW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(LANES - 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StReq   = 3'd1;
    localparam logic [2:0] StWaitR = 3'd2;
    localparam logic [2:0] StDone  = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [LaneW-1:0]        lane_q, lane_d;
    logic                    store_q, half_q;
    logic [ADDR_W-1:0]       base_q;
    logic [LANES*DATA_W-1:0] svec_q;
    logic                    busy_q, done_q, err_q, req_q, we_q, size_q;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [LANES*DATA_W-1:0] lvec_q, lvec_d;

    logic                    accept;
    logic                    flush_act;
    logic                    op_store, op_half;
    logic [ADDR_W-1:0]       op_base, offs;
    logic [LANES*DATA_W-1:0] op_vec;
    logic [DATA_W-1:0]       elem;

`ifdef VMEM_FLUSH_EN
    assign flush_act = flush;
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign flush_act    = 1'b0;
`endif

    assign accept = start && (state_q == StIdle);

    // The first request is built from the live inputs, later ones from the latched copy.
    assign op_store = accept ? is_store  : store_q;
    assign op_half  = accept ? is_half   : half_q;
    assign op_base  = accept ? base_addr : base_q;
    assign op_vec   = accept ? store_vec : svec_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        lvec_d  = lvec_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StReq;
                    lane_d  = '0;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    if (!store_q) begin
                        state_d = flush_act ? StDrain : StWaitR;
                    end else if (flush_act) begin
                        state_d = StIdle;
                    end else if (lane_q == LastLane) begin
                        state_d = StDone;
                    end else begin
                        lane_d = lane_q + LaneW'(1);
                    end
                end else if (flush_act) begin
                    state_d = StIdle;
                end
            end
            StWaitR: begin
                if (mem_rvalid) begin
                    if (flush_act) begin
                        state_d = StIdle;
                    end else begin
                        lvec_d[lane_q*DATA_W +: DATA_W] =
                            half_q ? DATA_W'(mem_rdata[15:0]) : mem_rdata;
                        if (lane_q == LastLane) begin
                            state_d = StDone;
                        end else begin
                            lane_d  = lane_q + LaneW'(1);
                            state_d = StReq;
                        end
                    end
                end else if (flush_act) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Address and write data are recomputed only for the lane being requested next,
    // so they stay stable while a request waits for its grant.
    always_comb begin
        elem    = op_vec[lane_d*DATA_W +: DATA_W];
        offs    = op_half ? (ADDR_W'(lane_d) << 1) : (ADDR_W'(lane_d) << 2);
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (state_d == StReq) begin
            addr_d  = op_base + offs;
            wdata_d = op_half ? DATA_W'(elem[15:0]) : elem;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            lane_q  <= '0;
            store_q <= 1'b0;
            half_q  <= 1'b0;
            base_q  <= '0;
            svec_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            lvec_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (accept) begin
                store_q <= is_store;
                half_q  <= is_half;
                base_q  <= base_addr;
                svec_q  <= store_vec;
            end
            busy_q  <= (state_d == StReq) || (state_d == StWaitR) || (state_d == StDrain);
            done_q  <= (state_d == StDone);
            err_q   <= start && (state_q != StIdle);
            req_q   <= (state_d == StReq);
            we_q    <= (state_d == StReq) && op_store;
            size_q  <= (state_d == StReq) && op_half;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            lvec_q  <= lvec_d;
        end
    end

    assign stall     = busy_q | accept;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign load_vec  = lvec_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_vmem_sequencer.sv
// Self-checking bench for vmem_sequencer: directed scenarios plus randomized ops against a
// transaction-level model; the flush scenario is built only with VMEM_FLUSH_EN.
module tb_vmem_sequencer;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned VW     = LANES * DATA_W;
`ifdef VMEM_FLUSH_EN
    localparam bit FlushEn = 1'b1;
`else
    localparam bit FlushEn = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, is_store = 1'b0, is_half = 1'b0, flush = 1'b0;
    logic [31:0]   base_addr = '0;
    logic [VW-1:0] store_vec = '0;
    logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          stall, busy, done, err, mem_req, mem_we, mem_size;
    logic [VW-1:0] load_vec;
    logic [31:0]   mem_addr, mem_wdata;

    vmem_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .is_half(is_half),
        .base_addr(base_addr), .store_vec(store_vec), .flush(flush), .stall(stall),
        .busy(busy), .done(done), .err(err), .load_vec(load_vec), .mem_req(mem_req),
        .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int          g_tab[LANES], r_tab[LANES];
    int          req_idx = 0, g_wait = 0, rd_cnt = 0, gnt_count = 0, req108 = 0, rd_mode = 0;
    bit          rd_pend = 1'b0;
    logic [31:0] rd_addr = '0, rd_const = '0, seed = 32'h1234_5678;
    logic [31:0] log_addr[$], log_wdata[$];
    bit          log_size[$];

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        if (rd_mode == 0) return a;
        if (rd_mode == 1) return rd_const;
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    always begin
        @(posedge clk);
        #2;
        mem_rvalid = 1'b0;
        if (rd_pend) begin
            if (rd_cnt <= 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdata_of(rd_addr);
                rd_pend    = 1'b0;
            end else begin
                rd_cnt--;
            end
        end
        mem_gnt = 1'b0;
        if (mem_req) begin
            if (mem_addr == 32'h108) req108++;
            if (g_wait == 0) begin
                mem_gnt = 1'b1;
                gnt_count++;
                log_addr.push_back(mem_addr);
                log_wdata.push_back(mem_wdata);
                log_size.push_back(mem_size);
                if (!mem_we) begin
                    rd_pend = 1'b1;
                    rd_cnt  = (req_idx < LANES) ? r_tab[req_idx] : 1;
                    rd_addr = mem_addr;
                end
                req_idx++;
                g_wait = (req_idx < LANES) ? g_tab[req_idx] : 0;
            end else begin
                g_wait--;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    // Phase: 0 idle, 1 transferring lanes, 2 completion cycle, 3 draining an aborted read.
    int          m_phase = 0, m_xfers = 0;
    bit          m_store = 1'b0, m_half = 1'b0, m_rd_out = 1'b0, m_err = 1'b0;
    logic [31:0] m_addr[LANES], m_wdata[LANES], m_vec[LANES];

    initial for (int i = 0; i < LANES; i++) m_vec[i] = '0;

    always @(negedge clk) begin
        logic [VW-1:0] pv;
        bit exp_busy, exp_req, fl, nerr;
        for (int i = 0; i < LANES; i++) pv[i*32 +: 32] = m_vec[i];
        exp_busy = (m_phase == 1) || (m_phase == 3);
        exp_req  = (m_phase == 1) && !m_rd_out;
        check("mdl_busy", VW'(busy), VW'(exp_busy));
        check("mdl_stall", VW'(stall), VW'(exp_busy || (start && m_phase == 0)));
        check("mdl_done", VW'(done), VW'(m_phase == 2));
        check("mdl_err", VW'(err), VW'(m_err));
        check("mdl_load_vec", load_vec, pv);
        check("mdl_mem_req", VW'(mem_req), VW'(exp_req));
        if (exp_req && mem_req && m_xfers < LANES) begin
            check("mdl_addr", VW'(mem_addr), VW'(m_addr[m_xfers]));
            check("mdl_we", VW'(mem_we), VW'(m_store));
            check("mdl_size", VW'(mem_size), VW'(m_half));
            if (m_store) check("mdl_wdata", VW'(mem_wdata), VW'(m_wdata[m_xfers]));
        end
        if (!rst_n) begin
            m_phase = 0; m_rd_out = 1'b0; m_err = 1'b0;
            for (int i = 0; i < LANES; i++) m_vec[i] = '0;
        end else begin
            nerr = start && (m_phase != 0);
            fl   = FlushEn && flush;
            case (m_phase)
                0: if (start) begin
                    m_store = is_store; m_half = is_half; m_xfers = 0; m_rd_out = 1'b0;
                    for (int i = 0; i < LANES; i++) begin
                        m_addr[i]  = base_addr + 32'(i) * (is_half ? 32'd2 : 32'd4);
                        m_wdata[i] = is_half ? {16'h0, store_vec[i*32 +: 16]}
                                             : store_vec[i*32 +: 32];
                    end
                    m_phase = 1;
                end
                1: if (m_rd_out) begin
                    if (mem_rvalid) begin
                        m_rd_out = 1'b0;
                        if (fl) m_phase = 0;
                        else begin
                            m_vec[m_xfers] = m_half ? {16'h0, mem_rdata[15:0]} : mem_rdata;
                            m_xfers++;
                            if (m_xfers == LANES) m_phase = 2;
                        end
                    end else if (fl) m_phase = 3;
                end else if (mem_gnt) begin
                    if (m_store) begin
                        m_xfers++;
                        if (fl) m_phase = 0;
                        else if (m_xfers == LANES) m_phase = 2;
                    end else begin
                        m_rd_out = 1'b1;
                        if (fl) m_phase = 3;
                    end
                end else if (fl) m_phase = 0;
                2: m_phase = 0;
                3: if (mem_rvalid) m_phase = 0;
                default: m_phase = 0;
            endcase
            m_err = nerr;
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] ea[LANES];

    task automatic set_tabs(input int g, input int r);
        for (int i = 0; i < LANES; i++) begin g_tab[i] = g; r_tab[i] = r; end
    endtask

    task automatic check_addrs(input string nm);
        check({nm, "_ngnt"}, VW'(log_addr.size()), VW'(LANES));
        if (log_addr.size() == LANES)
            for (int i = 0; i < LANES; i++) check({nm, "_addr"}, VW'(log_addr[i]), VW'(ea[i]));
    endtask

    task automatic run_op(input bit st, input bit hf, input logic [31:0] base,
                          input logic [VW-1:0] vec, input int err_at,
                          output int done_cyc, output int stall_cnt, output int err_cnt);
        int cyc;
        @(posedge clk);
        #1;
        log_addr.delete(); log_wdata.delete(); log_size.delete();
        req_idx = 0; g_wait = g_tab[0];
        start = 1'b1; is_store = st; is_half = hf; base_addr = base; store_vec = vec;
        done_cyc = -1; stall_cnt = 0; err_cnt = 0; cyc = 0;
        #2;
        if (stall) stall_cnt++;
        while (cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == err_at);
            if (start) begin is_store = 1'($urandom); base_addr = $urandom; end
            if (!FlushEn) flush = 1'($urandom);
            #2;
            if (stall) stall_cnt++;
            if (err) err_cnt++;
            if (done) begin done_cyc = cyc; break; end
        end
        start = 1'b0;
        flush = 1'b0;
        check("op_done_seen", VW'(done_cyc >= 0), VW'(1));
    endtask

    initial begin
        int dc, sc, ec, n, dn, bc;
        logic [VW-1:0] v;
        set_tabs(0, 1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        check("rst_busy", VW'(busy), '0);
        check("rst_stall", VW'(stall), '0);
        check("rst_mem_req", VW'(mem_req), '0);
        check("rst_mem_addr", VW'(mem_addr), '0);
        check("rst_load_vec", load_vec, '0);

        // VLDW best case
        rd_mode = 0;
        run_op(1'b0, 1'b0, 32'h100, '0, -1, dc, sc, ec);
        check("vldw_done_cycle", VW'(dc), VW'(9));
        check("vldw_stall_cycles", VW'(sc), VW'(9));
        check("vldw_load_vec", load_vec, {32'h10C, 32'h108, 32'h104, 32'h100});
        ea = '{32'h100, 32'h104, 32'h108, 32'h10C};
        check_addrs("vldw");

        // VSTB across a 0x200 boundary
        run_op(1'b1, 1'b1, 32'h1FE, {32'hDDDD4444, 32'hCCCC3333, 32'hBBBB2222, 32'hAAAA1111},
               -1, dc, sc, ec);
        check("vstb_done_cycle", VW'(dc), VW'(5));
        check("vstb_load_vec_kept", load_vec, {32'h10C, 32'h108, 32'h104, 32'h100});
        ea = '{32'h1FE, 32'h200, 32'h202, 32'h204};
        check_addrs("vstb");
        if (log_wdata.size() == LANES) begin
            check("vstb_wdata0", VW'(log_wdata[0]), VW'(32'h0000_1111));
            check("vstb_wdata3", VW'(log_wdata[3]), VW'(32'h0000_4444));
            check("vstb_size", VW'(log_size[1]), VW'(1));
        end

        // grant withheld three cycles on lane 2
        g_tab[2] = 3;
        req108 = 0;
        run_op(1'b0, 1'b0, 32'h100, '0, -1, dc, sc, ec);
        check("gnt_hold_done_cycle", VW'(dc), VW'(12));
        check("gnt_hold_req_cycles", VW'(req108), VW'(4));

        // VLDH with address wrap and a rejected start at cycle 3
        set_tabs(0, 1);
        rd_mode = 1; rd_const = 32'hFFFF_8001;
        run_op(1'b0, 1'b1, 32'hFFFF_FFFC, '0, 3, dc, sc, ec);
        check("vldh_done_cycle", VW'(dc), VW'(9));
        check("vldh_err_pulses", VW'(ec), VW'(1));
        check("vldh_load_vec", load_vec, {4{32'h0000_8001}});
        ea = '{32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0, 32'h2};
        check_addrs("vldh");

        // reset while waiting for lane 1 read data; its rvalid arrives after reset
        set_tabs(0, 3);
        rd_mode = 0;
        @(posedge clk);
        #1;
        req_idx = 0; g_wait = 0; gnt_count = 0;
        start = 1'b1; is_store = 1'b0; is_half = 1'b0; base_addr = 32'h100;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (gnt_count < 2 && n < 50) begin @(posedge clk); #1; n++; end
        check("rst_mid_reached", VW'(gnt_count), VW'(2));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        check("rst_mid_busy", VW'(busy), '0);
        check("rst_mid_mem_req", VW'(mem_req), '0);
        check("rst_mid_mem_addr", VW'(mem_addr), '0);
        check("rst_mid_load_vec", load_vec, '0);
        repeat (4) @(posedge clk);
        #3;
        check("rst_late_rvalid_load_vec", load_vec, '0);

`ifdef VMEM_FLUSH_EN
        // flush while waiting for lane 2, data returns two cycles later
        r_tab = '{1, 1, 3, 1};
        @(posedge clk);
        #1;
        req_idx = 0; g_wait = 0; gnt_count = 0;
        start = 1'b1; is_store = 1'b0; is_half = 1'b0; base_addr = 32'h100;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (gnt_count < 3 && n < 50) begin @(posedge clk); #1; n++; end
        flush = 1'b1;
        dn = 0; bc = 0; n = 0;
        #2;
        while (busy && n < 30) begin
            bc++;
            @(posedge clk);
            #1;
            flush = 1'b0;
            n++;
            #2;
            if (done) dn++;
        end
        check("flush_busy_cycles", VW'(bc), VW'(3));
        check("flush_no_done", VW'(dn), '0);
        check("flush_load_vec", load_vec, {32'h0, 32'h0, 32'h104, 32'h100});
        set_tabs(0, 1);
        run_op(1'b0, 1'b0, 32'h100, '0, -1, dc, sc, ec);
        check("flush_restart_done_cycle", VW'(dc), VW'(9));
`endif

        // randomized operations
        rd_mode = 2;
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < LANES; i++) begin
                g_tab[i] = $urandom_range(0, 3);
                r_tab[i] = $urandom_range(1, 3);
            end
            for (int i = 0; i < LANES; i++) v[i*32 +: 32] = $urandom;
            seed = $urandom;
            n = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : -1;
            run_op(1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom,
                   v, n, dc, sc, ec);
            check("rand_err_pulses", VW'(ec), VW'(n > 0));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vmem_sequencer.md
Name: vmem_sequencer

Overview:
- Multi-cycle sequencer for the vector memory instructions VLDW, VLDH, VSTW and VSTB.
- Splits each vector access into LANES scalar accesses on the single shared data-memory port.
- Stalls the pipeline until the whole vector has been transferred.
- Sits beside the MEM stage. Started by the decoded vector-memory control signals; load results are returned to the vector register file write path.

Parameters:
- LANES, 4, number of vector elements per register.
- DATA_W, 32, element and memory data width.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a vector memory op.
- is_store  in  1  1 = VSTW/VSTB, 0 = VLDW/VLDH. Sampled with start.
- is_half  in  1  1 = halfword element (VLDH/VSTB), 0 = word. Sampled with start.
- base_addr  in  ADDR_W  byte address of lane 0. Sampled with start.
- store_vec  in  LANES*DATA_W  store data. Lane i is bits [i*DATA_W +: DATA_W]. Sampled with start.
- flush  in  1  abort request. Used only with VMEM_FLUSH_EN.
- stall  out  1  hold the pipeline.
- busy  out  1  an operation is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse when start arrives while not IDLE.
- load_vec  out  LANES*DATA_W  assembled load result.
- mem_req  out  1  memory request valid.
- mem_we  out  1  write enable.
- mem_size  out  1  0 = word, 1 = halfword.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  DATA_W  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- All outputs are registered except stall.
- stall = busy | (start & state==IDLE), so the pipeline freezes in the same cycle start is seen.
- Reset, or rst_n=0 at any clock edge including mid-operation: state=IDLE, lane=0; busy, done, err, mem_req, mem_we, mem_size = 0; mem_addr = 0, mem_wdata = 0, load_vec = 0.
- States: IDLE, REQ, WAIT_R, DONE, DRAIN. DRAIN is used only with VMEM_FLUSH_EN.
- IDLE:
  - start=1: latch the operands, lane=0, go to REQ.
  - mem_rvalid is ignored.
- REQ:
  - busy=1, mem_req=1, mem_we=is_store, mem_size=is_half.
  - Address: mem_addr = base + lane*stride. stride = 4 for word, 2 for half. Addition is modulo 2^ADDR_W (wraps).
  - mem_wdata = lane element for word stores. For half stores it is {16'b0, element[15:0]}.
  - mem_req, mem_addr and mem_wdata stay stable until mem_gnt=1.
  - On gnt, store: go to DONE if lane==LANES-1, else lane+1 and stay in REQ.
  - On gnt, load: go to WAIT_R.
- WAIT_R:
  - mem_req=0. At most one read is outstanding.
  - On mem_rvalid, write load_vec lane slot: mem_rdata for word loads, zero-extended mem_rdata[15:0] for half loads.
  - Then go to DONE if lane==LANES-1, else lane+1 and go to REQ.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- load_vec lanes keep their previous value until overwritten. Stores never modify load_vec.
- err: start in any state other than IDLE is ignored and produces a one-cycle err pulse. The current operation is unaffected.
- Best-case latency (gnt in the REQ cycle, rvalid the cycle after gnt), with start in cycle 0:
  - Load: done in cycle 2*LANES+1.
  - Store: done in cycle LANES+1.

Optional Feature:
- Macro: VMEM_FLUSH_EN.
- Defined:
  - flush=1 in REQ without a same-cycle gnt: go to IDLE. No done; mem_req drops next cycle.
  - flush=1 in WAIT_R: go to DRAIN (busy=1, mem_req=0). Wait for mem_rvalid, discard the data, then go to IDLE with no done.
  - flush with a same-cycle gnt in REQ: the gnt is honoured first. A store then proceeds to IDLE; a load proceeds to DRAIN.
  - Lanes already written are preserved.
  - flush in IDLE or DONE has no effect.
- Not defined: the flush port is ignored and DRAIN is unreachable.

Test Plan:
- VLDW, base 0x100. Memory grants immediately, returns rdata=address one cycle later, start at cycle 0 → addresses 0x100, 0x104, 0x108, 0x10C; load_vec = {0x10C, 0x108, 0x104, 0x100}; done at cycle 9; stall high in cycles 0–8.
- VSTB, base 0x1FE, store_vec lanes = 0xAAAA1111, 0xBBBB2222, 0xCCCC3333, 0xDDDD4444 → writes to 0x1FE, 0x200, 0x202, 0x204; mem_size=1; wdata 0x00001111 … 0x00004444; done at cycle 5; load_vec unchanged.
- VLDW with mem_gnt withheld 3 cycles on lane 2 → mem_req and mem_addr=0x108 held stable; done at cycle 12.
- VLDH, base 0xFFFFFFFC, rdata=0xFFFF8001 → addresses wrap to 0xFFFFFFFC, 0xFFFFFFFE, 0x0, 0x2; every lane = 0x00008001. Also start pulsed at cycle 3 → err=1 for one cycle, result unchanged.
- rst_n=0 while in WAIT_R on lane 1 → next cycle all outputs 0 and state IDLE; a late mem_rvalid leaves load_vec = 0.
- (VMEM_FLUSH_EN) flush in WAIT_R on lane 2, rvalid 2 cycles later → busy held until rvalid; lanes 0–1 kept, lane 2 not written; no done pulse; a new start is accepted afterwards.
